// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM access engine and its open-row table.
package dram_pkg;
  localparam int NUM_OF_BANKS = 8;
  localparam int NUM_OF_ROWS  = 128;
  localparam int NUM_OF_COLS  = 8;
  localparam int DATA_WIDTH   = 1;

  localparam int BANK_W = $clog2(NUM_OF_BANKS);
  localparam int ROW_W  = $clog2(NUM_OF_ROWS);
  localparam int COL_W  = $clog2(NUM_OF_COLS);

  localparam int WR_LAT      = 1;
  localparam int RD_HIT_LAT  = 2;
  localparam int RD_MISS_LAT = 4;

  typedef enum logic [2:0] {IDLE, WR, ACT1, ACT2, RD, CAP, DONE} state_e;

  typedef struct packed {
    logic                  we;
    logic [BANK_W-1:0]     bank;
    logic [ROW_W-1:0]      row;
    logic [COL_W-1:0]      col;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;
endpackage

// File: rtl/dram_open_row_table.sv
// Per-bank open-row tracker: valid bit plus row tag, looked up with the incoming
// request and updated from the in-flight one.
module dram_open_row_table
  import dram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BANK_W-1:0] lk_bank,
  input  logic [ROW_W-1:0]  lk_row,
  output logic              lk_hit,
  input  logic              set_en,
  input  logic              inv_en,
  input  logic [BANK_W-1:0] upd_bank,
  input  logic [ROW_W-1:0]  upd_row
);
  logic [NUM_OF_BANKS-1:0]            vld_q, vld_d;
  logic [NUM_OF_BANKS-1:0][ROW_W-1:0] tag_q, tag_d;

  always_comb lk_hit = vld_q[lk_bank] && (tag_q[lk_bank] == lk_row);

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    // A direct array write leaves the row buffer stale for that row.
    if (inv_en && vld_q[upd_bank] && (tag_q[upd_bank] == upd_row))
      vld_d[upd_bank] = 1'b0;
    if (set_en) begin
      vld_d[upd_bank] = 1'b1;
      tag_d[upd_bank] = upd_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end
endmodule

// File: rtl/dram_access_engine.sv
// Host-to-banked-DRAM sequencer: write, activate and buffered column read phases.
// DRAM_ACCESS_ROW_HIT_EN enables the open-row table so repeat-row reads skip the activate.
module dram_access_engine
  import dram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [BANK_W-1:0]     req_bank,
  input  logic [ROW_W-1:0]      req_row,
  input  logic [COL_W-1:0]      req_col,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_hit,
  output logic                  bank_rw,
  output logic                  buffer_rw,
  output logic [BANK_W-1:0]     bank_id,
  output logic [ROW_W-1:0]      rowid,
  output logic [COL_W-1:0]      colid,
  inout  wire  [DATA_WIDTH-1:0] data
);
  state_e                state_q, state_d;
  req_t                  req_q, req_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  hit_q, hit_d;
  logic                  hit;

`ifdef DRAM_ACCESS_ROW_HIT_EN
  dram_open_row_table u_tbl (
    .clk      (clk),
    .rst      (rst),
    .lk_bank  (req_bank),
    .lk_row   (req_row),
    .lk_hit   (hit),
    .set_en   (state_q == ACT2),
    .inv_en   (state_q == WR),
    .upd_bank (req_q.bank),
    .upd_row  (req_q.row)
  );
`else
  assign hit = 1'b0;
`endif

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign bank_rw   = (state_q == WR);
  assign buffer_rw = (state_q == ACT1) || (state_q == ACT2);
  assign bank_id   = req_q.bank;
  assign rowid     = req_q.row;
  assign colid     = req_q.col;
  assign rsp_rdata = rdata_q;
  assign rsp_hit   = hit_q;
  assign data      = bank_rw ? req_q.wdata : {DATA_WIDTH{1'bz}};

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    hit_d   = hit_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        req_d   = '{we: req_we, bank: req_bank, row: req_row, col: req_col, wdata: req_wdata};
        rdata_d = '0;
        hit_d   = !req_we && hit;
        if (req_we)   state_d = WR;
        else if (hit) state_d = RD;
        else          state_d = ACT1;
      end
      WR:   state_d = DONE;
      ACT1: state_d = ACT2;
      ACT2: state_d = RD;
      RD:   state_d = CAP;
      // The memory drives the buffered column while both strobes are low.
      CAP: begin
        rdata_d = data;
        state_d = DONE;
      end
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
    end
  end
endmodule

// File: tb/tb_dram_access_engine.sv
// Self-checking bench: banked DRAM device model, functional reference model, per-cycle monitor.
module tb_dram_access_engine;
  import dram_pkg::*;

`ifdef DRAM_ACCESS_ROW_HIT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic                  req_we = 1'b0;
  logic [BANK_W-1:0]     req_bank = '0;
  logic [ROW_W-1:0]      req_row = '0;
  logic [COL_W-1:0]      req_col = '0;
  logic [DATA_WIDTH-1:0] req_wdata = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_hit;
  logic                  bank_rw, buffer_rw;
  logic [BANK_W-1:0]     bank_id;
  logic [ROW_W-1:0]      rowid;
  logic [COL_W-1:0]      colid;
  wire  [DATA_WIDTH-1:0] data;

  dram_access_engine dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit),
    .bank_rw(bank_rw), .buffer_rw(buffer_rw),
    .bank_id(bank_id), .rowid(rowid), .colid(colid), .data(data)
  );

  always #5 clk = ~clk;

  // Device: array written directly, row buffer loaded by activate, buffer drives the bus.
  logic [NUM_OF_COLS-1:0] dev_mem [NUM_OF_BANKS][NUM_OF_ROWS];
  logic [NUM_OF_COLS-1:0] dev_buf [NUM_OF_BANKS];
  assign data = (!bank_rw && !buffer_rw) ? dev_buf[bank_id][colid] : 1'bz;
  always @(posedge clk) begin
    if (bank_rw)        dev_mem[bank_id][rowid][colid] <= data[0];
    else if (buffer_rw) dev_buf[bank_id] <= dev_mem[bank_id][rowid];
  end

  // Reference: latest written value per cell, plus which row each bank has open.
  bit ref_mem [NUM_OF_BANKS][NUM_OF_ROWS][NUM_OF_COLS];
  bit open_v  [NUM_OF_BANKS];
  int open_r  [NUM_OF_BANKS];

  int n_chk = 0, n_fail = 0;
  bit inflight = 1'b0, seen_valid = 1'b0;
  int k, exp_lat, exp_rdata, exp_hit, exp_buf, exp_bw, exp_bank, exp_row, exp_col;
  int last_lat, last_rdata, last_hit, last_buf;

  function automatic void chkv(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_accept(input bit we, input int b, input int r, input int c, input bit wd);
    bit h;
    exp_bank = b; exp_row = r; exp_col = c;
    if (we) begin
      ref_mem[b][r][c] = wd;
      if (open_v[b] && open_r[b] == r) open_v[b] = 1'b0;
      exp_lat = WR_LAT; exp_rdata = 0; exp_hit = 0; exp_buf = 0; exp_bw = 1;
    end else begin
      h = HIT_EN && open_v[b] && open_r[b] == r;
      exp_rdata = int'(ref_mem[b][r][c]);
      exp_hit = int'(h);
      exp_lat = h ? RD_HIT_LAT : RD_MISS_LAT;
      exp_buf = h ? 0 : 2;
      exp_bw  = 0;
      open_v[b] = 1'b1; open_r[b] = r;
    end
    k = -1; seen_valid = 1'b0; inflight = 1'b1;
  endfunction

  always @(negedge clk) begin
    chkv("strobe_exclusive", int'(bank_rw && buffer_rw), 0);
    if (!rst) begin
      if (!inflight) begin
        chkv("idle_rsp_valid", int'(rsp_valid), 0);
        chkv("idle_req_ready", int'(req_ready), 1);
        chkv("idle_strobes", int'({bank_rw, buffer_rw}), 0);
      end else begin
        k++;
        chkv("bank_id", int'(bank_id), exp_bank);
        chkv("rowid", int'(rowid), exp_row);
        chkv("colid", int'(colid), exp_col);
        chkv("busy_req_ready", int'(req_ready), 0);
        chkv("rsp_valid_timing", int'(rsp_valid), int'(k >= exp_lat));
        if (!seen_valid) begin
          exp_buf -= int'(buffer_rw);
          exp_bw  -= int'(bank_rw);
        end
        if (rsp_valid) begin
          if (!seen_valid) begin
            seen_valid = 1'b1;
            last_lat = k; last_rdata = int'(rsp_rdata); last_hit = int'(rsp_hit);
            last_buf = 2 - exp_buf;
            chkv("buffer_rw_cycles_left", exp_buf, 0);
            chkv("bank_rw_cycles_left", exp_bw, 0);
          end
          chkv("rsp_rdata", int'(rsp_rdata), exp_rdata);
          chkv("rsp_hit", int'(rsp_hit), exp_hit);
          if (rsp_ready) inflight = 1'b0;
        end
      end
    end
  end

  task automatic issue(input bit we, input int b, input int r, input int c, input bit wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_bank = BANK_W'(b); req_row = ROW_W'(r);
    req_col = COL_W'(c); req_wdata = DATA_WIDTH'(wd);
    @(posedge clk); #1;
    req_valid = 1'b0;
    model_accept(we, b, r, c, wd);
  endtask

  task automatic do_req(input bit we, input int b, input int r, input int c, input bit wd, input int hold);
    rsp_ready = (hold == 0);
    issue(we, b, r, c, wd);
    if (hold > 0) begin
      for (int i = 0; i < 40 && !seen_valid; i++) @(posedge clk);
      repeat (hold) @(posedge clk);
      #1 rsp_ready = 1'b1;
    end
    for (int i = 0; i < 40 && inflight; i++) @(negedge clk);
    chkv("rsp_timeout", int'(inflight), 0);
    inflight = 1'b0;
    rsp_ready = 1'b1;
  endtask

  initial begin
    for (int b = 0; b < NUM_OF_BANKS; b++) begin
      dev_buf[b] = '0; open_v[b] = 1'b0; open_r[b] = 0;
      for (int r = 0; r < NUM_OF_ROWS; r++) begin
        dev_mem[b][r] = '0;
        for (int c = 0; c < NUM_OF_COLS; c++) ref_mem[b][r][c] = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chkv("rst_req_ready", int'(req_ready), 1);
    chkv("rst_rsp_valid", int'(rsp_valid), 0);
    chkv("rst_strobes", int'({bank_rw, buffer_rw}), 0);
    chkv("rst_addr", int'({bank_id, rowid, colid}), 0);
    chkv("rst_rsp_fields", int'({rsp_rdata, rsp_hit}), 0);

    do_req(1'b1, 3, 17, 5, 1'b1, 0);
    chkv("wr_latency", last_lat, 1);
    do_req(1'b0, 3, 17, 5, 1'b0, 0);
    chkv("miss_latency", last_lat, 4);
    chkv("miss_buffer_cycles", last_buf, 2);
    chkv("miss_rdata", last_rdata, 1);
    chkv("miss_hit", last_hit, 0);

    do_req(1'b0, 3, 17, 2, 1'b0, 0);
    chkv("hit_latency", last_lat, HIT_EN ? 2 : 4);
    chkv("hit_rdata", last_rdata, 0);
    chkv("hit_flag", last_hit, HIT_EN ? 1 : 0);

    do_req(1'b0, 3, 17, 1, 1'b0, 0);
    do_req(1'b1, 3, 17, 0, 1'b1, 0);
    do_req(1'b0, 3, 17, 0, 1'b0, 0);
    chkv("coherent_latency", last_lat, 4);
    chkv("coherent_rdata", last_rdata, 1);
    chkv("coherent_hit", last_hit, 0);

    // Abort a miss during ACT2: no response, and the row stays closed.
    issue(1'b0, 0, 5, 0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; inflight = 1'b0;
    for (int b = 0; b < NUM_OF_BANKS; b++) open_v[b] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    do_req(1'b0, 0, 5, 0, 1'b0, 0);
    chkv("post_abort_latency", last_lat, 4);
    chkv("post_abort_hit", last_hit, 0);

    do_req(1'b0, 3, 17, 5, 1'b0, 6);
    chkv("hold_rdata", last_rdata, 1);

    for (int n = 0; n < 300; n++)
      do_req($urandom_range(0, 99) < 35, $urandom_range(0, 7), $urandom_range(0, 3),
             $urandom_range(0, 7), $urandom_range(0, 1), ($urandom_range(0, 9) == 0) ? 3 : 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
